relu_maxpool: RTL and testbench

Post-convolution stage directly downstream of the 5x5 convolution engine. It consumes the engine's `conv_valid`/`conv_data` stream: one result per valid beat, 28 per row, 28 rows per frame. It applies ReLU and requantizes each result to the 9-bit signed activation format used by the convolution inputs. It then performs 2x2 stride-2 max pooling and emits a 14x14 feature map to the next layer's window loader.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/relu_quant.sv | 28 ++
 rtl/relu_maxpool.sv | 126 ++++++++++++
 tb/tb_relu_maxpool.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared widths, frame geometry and small helpers for the CNN
//               datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int ACT_W   = 9;    // signed activation width
  localparam int CONV_W  = 22;   // convolution result width
  localparam int FMAP_W  = 28;   // conv results per row
  localparam int FMAP_H  = 28;   // rows per frame
  localparam int ACT_MAX = 255;  // activation saturation ceiling

  // Unsigned 8-bit maximum, shared by both pooling directions
  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/relu_quant.sv
`default_nettype none
// ============================================================================
// Module      : relu_quant
// Description : Combinational ReLU, arithmetic rescale by SHIFT and saturation
//               to an 8-bit unsigned activation.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_quant
  import cnn_pkg::*;
#(
  parameter int DW    = CONV_W,
  parameter int SHIFT = 8
) (
  input  logic signed [DW-1:0] d_i,
  output logic        [7:0]    a_o
);

  logic [DW-1:0] w_relu;
  logic [DW-1:0] w_shifted;

  // Negative results clamp to zero; after that the value is non-negative,
  // so a logical shift is equivalent to the arithmetic one.
  assign w_relu    = d_i[DW-1] ? '0 : d_i;
  assign w_shifted = w_relu >> SHIFT;
  assign a_o       = (w_shifted > DW'(ACT_MAX)) ? 8'(ACT_MAX) : w_shifted[7:0];

endmodule
`default_nettype wire

// File: rtl/relu_maxpool.sv
`default_nettype none
// ============================================================================
// Module      : relu_maxpool
// Description : ReLU + requantize each conv result, then 2x2 stride-2 max
//               pooling using a half-row line buffer. Outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool
  import cnn_pkg::*;
#(
  parameter int IN_W  = FMAP_W,
  parameter int IN_H  = FMAP_H,
  parameter int SHIFT = 8,
  parameter int DW    = CONV_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    conv_valid,
  input  logic signed [DW-1:0]    conv_data,
  output logic                    pool_valid,
  output logic signed [ACT_W-1:0] pool_data,
  output logic                    row_done,
  output logic                    frame_done
);

  localparam int c_COL_W = $clog2(IN_W);
  localparam int c_ROW_W = $clog2(IN_H);
  localparam int c_LB_D  = IN_W / 2;
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IN_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IN_H - 1);

  logic [c_COL_W-1:0] col_q, col_d, w_col;
  logic [c_ROW_W-1:0] row_q, row_d, w_row;
  logic [7:0]         hold_q, hold_d, w_hold;
  logic [7:0]         w_act, w_pm, w_lb_rd, w_pool;
  logic [c_COL_W-2:0] w_lb_idx;
  logic               w_lb_we;
  logic [7:0]         linebuf_q [c_LB_D];

  logic               pool_valid_q, pool_valid_d;
  logic [ACT_W-1:0]   pool_data_q, pool_data_d;
  logic               row_done_q, row_done_d;
  logic               frame_done_q, frame_done_d;

  relu_quant #(
    .DW    (DW),
    .SHIFT (SHIFT)
  ) u_relu_quant (
    .d_i (conv_data),
    .a_o (w_act)
  );

  // Position decode, horizontal/vertical max and next-state for all registers.
  // clr makes the current beat look like (0,0) with an empty hold register.
  always_comb begin
    w_col        = clr ? '0 : col_q;
    w_row        = clr ? '0 : row_q;
    w_hold       = clr ? '0 : hold_q;
    col_d        = w_col;
    row_d        = w_row;
    hold_d       = w_hold;
    w_pm         = max_u8(w_hold, w_act);
    w_lb_idx     = w_col[c_COL_W-1:1];
    w_lb_rd      = linebuf_q[w_lb_idx];
    w_pool       = max_u8(w_lb_rd, w_pm);
    w_lb_we      = conv_valid && w_col[0] && !w_row[0];
    pool_valid_d = 1'b0;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    pool_data_d  = pool_data_q;
    if (conv_valid) begin
      if (!w_col[0]) begin
        hold_d = w_act;
      end
      if (w_col == c_COL_LAST) begin
        col_d = '0;
        row_d = (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        col_d = w_col + 1'b1;
      end
      if (w_col[0] && w_row[0]) begin
        pool_valid_d = 1'b1;
        pool_data_d  = {1'b0, w_pool};
        row_done_d   = (w_col == c_COL_LAST);
        frame_done_d = (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);
      end
    end
  end

  // Position counters, hold register and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      pool_valid_q <= 1'b0;
      pool_data_q  <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      pool_valid_q <= pool_valid_d;
      pool_data_q  <= pool_data_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer: even rows store horizontal maxima, odd rows only read them,
  // so it needs no reset and never sees a same-index read/write collision.
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      linebuf_q[w_lb_idx] <= w_pm;
    end
  end

  assign pool_valid = pool_valid_q;
  assign pool_data  = pool_data_q;
  assign row_done   = row_done_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool
// Description : Self-checking bench for relu_maxpool against a frame-array
//               reference model (quantize every pixel, pool 2x2 blocks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool;

  localparam int W   = 28;
  localparam int H   = 28;
  localparam int DWT = 22;
  localparam int SH  = 8;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  clr = 1'b0;
  logic                  conv_valid = 1'b0;
  logic signed [DWT-1:0] conv_data = '0;
  logic                  pool_valid;
  logic signed [8:0]     pool_data;
  logic                  row_done;
  logic                  frame_done;

  always #5 clk = ~clk;

  relu_maxpool #(
    .IN_W  (W),
    .IN_H  (H),
    .SHIFT (SH),
    .DW    (DWT)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .conv_valid (conv_valid),
    .conv_data  (conv_data),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .row_done   (row_done),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: a whole frame of quantized activations
  int         act [H][W];
  int         pos = 0;
  logic [2:0] exp_flags = 3'b000;
  logic [8:0] exp_data = 9'd0;
  int         n_valid = 0;
  int         n_row = 0;
  int         n_frame = 0;

  function automatic int quant(input int v);
    int q;
    if (v < 0) return 0;
    q = v / (1 << SH);
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int data_for(input int mode, input int r, input int c);
    int sel;
    case (mode)
      0: begin
        if (r == 0 && c == 0) return 512;
        if (r == 0 && c == 1) return -300;
        if (r == 1 && c == 0) return 1024;
        if (r == 1 && c == 1) return 256;
        return 0;
      end
      1: return 32'h1FFFFF;
      2: return -1;
      3: return (r * W + c) * 64;
      default: begin
        sel = int'($urandom_range(0, 3));
        if (sel == 0) return int'($urandom) >>> 10;
        if (sel == 1) return int'($urandom_range(0, 70000));
        if (sel == 2) return -int'($urandom_range(0, 5000));
        return int'($urandom_range(0, 65535));
      end
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert ({pool_valid, row_done, frame_done} === exp_flags) else begin
      errors++;
      $error("FAIL %s strobes(valid,row,frame) got %b expected %b", tag,
             {pool_valid, row_done, frame_done}, exp_flags);
    end
    checks++;
    assert (pool_data === exp_data) else begin
      errors++;
      $error("FAIL %s pool_data got %0d expected %0d", tag, pool_data, exp_data);
    end
    if (pool_valid === 1'b1) n_valid++;
    if (row_done === 1'b1) n_row++;
    if (frame_done === 1'b1) n_frame++;
  endtask

  // One clock: apply inputs, advance the model, check registered outputs
  task automatic step(input logic v, input int d, input logic c, input string tag);
    int r;
    int k;
    int m;
    conv_valid = v;
    conv_data  = DWT'(d);
    clr        = c;
    exp_flags  = 3'b000;
    if (c) pos = 0;
    if (v) begin
      r = pos / W;
      k = pos % W;
      act[r][k] = quant(d);
      if ((r % 2 == 1) && (k % 2 == 1)) begin
        m = imax(imax(act[r-1][k-1], act[r-1][k]), imax(act[r][k-1], act[r][k]));
        exp_data  = 9'(m);
        exp_flags = {1'b1, k == W - 1, (k == W - 1) && (r == H - 1)};
      end
      pos = (pos + 1) % (W * H);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    conv_valid = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic run_beats(input int n, input int mode, input int gap,
                           input int rowgap, input string tag);
    for (int i = 0; i < n; i++) begin
      int r;
      int c;
      r = pos / W;
      c = pos % W;
      step(1'b1, data_for(mode, r, c), 1'b0, tag);
      repeat (gap) step(1'b0, 0, 1'b0, tag);
      if (c == W - 1) repeat (rowgap) step(1'b0, 0, 1'b0, tag);
    end
  endtask

  task automatic check_counts(input string tag, input int ev, input int er, input int ef);
    checks++;
    assert (n_valid == ev && n_row == er && n_frame == ef) else begin
      errors++;
      $error("FAIL %s counts(valid,row,frame) got %0d,%0d,%0d expected %0d,%0d,%0d",
             tag, n_valid, n_row, n_frame, ev, er, ef);
    end
    n_valid = 0;
    n_row   = 0;
    n_frame = 0;
  endtask

  initial begin
    // Reset held with beats toggling: everything stays at zero
    for (int i = 0; i < 6; i++) begin
      conv_valid = i[0];
      conv_data  = DWT'(1000 * (i + 1));
      @(posedge clk);
      #1;
      check_outputs("reset_hold");
    end
    conv_valid = 1'b0;
    rstn = 1'b1;
    step(1'b0, 0, 1'b0, "post_reset_idle");

    // Single window: quantized 2,0 / 4,1 -> first output 4
    run_beats(W + 2, 0, 0, 0, "window");
    checks++;
    assert (pool_valid === 1'b1 && pool_data === 9'sd4) else begin
      errors++;
      $error("FAIL window_first got valid=%b data=%0d expected valid=1 data=4",
             pool_valid, pool_data);
    end
    n_valid = 0; n_row = 0; n_frame = 0;
    run_beats(W * H - (W + 2), 0, 0, 0, "window_rest");
    check_counts("window_rest", 195, 14, 1);

    // Saturation both ways
    run_beats(W * H, 1, 0, 0, "sat_pos");
    check_counts("sat_pos", 196, 14, 1);
    run_beats(W * H, 2, 0, 0, "sat_neg");
    check_counts("sat_neg", 196, 14, 1);

    // Ramp frame with spaced beats and row gaps, twice back-to-back
    run_beats(W * H, 3, 7, 32, "ramp1");
    check_counts("ramp1", 196, 14, 1);
    run_beats(W * H, 3, 7, 32, "ramp2");
    check_counts("ramp2", 196, 14, 1);

    // Random frames, back-to-back and with random gaps
    run_beats(W * H, 4, 0, 0, "rand_b2b");
    check_counts("rand_b2b", 196, 14, 1);
    for (int i = 0; i < W * H; i++) begin
      run_beats(1, 4, int'($urandom_range(0, 2)), 0, "rand_gap");
    end
    check_counts("rand_gap", 196, 14, 1);

    // clr mid-frame at row 5 col 9, with a beat of 2560 in the same cycle
    run_beats(5 * W + 9, 4, 0, 0, "pre_clr");
    n_valid = 0; n_row = 0; n_frame = 0;
    step(1'b1, 2560, 1'b1, "clr_beat");
    run_beats(W * H - 1, 4, 0, 0, "post_clr");
    check_counts("post_clr", 196, 14, 1);

    // Async reset mid-row at row 3 col 17
    run_beats(3 * W + 17, 4, 0, 0, "pre_areset");
    rstn = 1'b0;
    #1;
    exp_flags = 3'b000;
    exp_data  = 9'd0;
    pos       = 0;
    check_outputs("areset_immediate");
    @(posedge clk);
    #1;
    check_outputs("areset_held");
    rstn = 1'b1;
    n_valid = 0; n_row = 0; n_frame = 0;
    run_beats(W * H, 4, 0, 0, "post_areset");
    check_counts("post_areset", 196, 14, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
